// File: rtl/irq_controller.sv
// irq_controller: CPU interrupt front end.
//   Synchronises raw interrupt lines and latches their rising edges as pending.
//   Applies a software mask and a fixed priority (highest index wins).
//   Presents one request, with its source id and entry vector, to the CPU.
//   Tracks in-service sources between acknowledge and exception return.
// Optional feature: define IRQ_NESTING_EN for nested (preemptive) service.
//   Without it, any in-service source blocks all new requests until eret.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   irq_in      raw asynchronous interrupt lines (rising edge = request)
//   mask_we     mask register write strobe
//   mask_din    mask write data (1 = masked)
//   eret        exception return; pops the highest in-service source
//   irq_ack     CPU takes the presented interrupt
//   irq_req     request to the CPU
//   irq_id      index of the presented source
//   irq_vector  entry address of the presented source
//   pending     latched edges not yet serviced
//   in_service  sources currently being serviced
//   mask        current mask register
module irq_controller #(
  parameter int unsigned N_SRC       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0020,
  localparam int unsigned ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_din,
  input  logic              eret,
  input  logic              irq_ack,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic [31:0]       irq_vector,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic [N_SRC-1:0]  mask
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] hist_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] in_service_q;
  logic [N_SRC-1:0] mask_q;

  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  win_id;
  logic             win_any;
  logic [ID_W-1:0]  srv_id;
  logic             srv_any;
  logic             block;
  logic             req_c;
  logic             ack_fire;
  logic [N_SRC-1:0] ack_set;
  logic [N_SRC-1:0] eret_clr;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Priority pick: highest-index eligible source and highest in-service source
  always_comb begin
    eligible = pending_q & ~mask_q;
    win_id   = '0;
    win_any  = 1'b0;
    srv_id   = '0;
    srv_any  = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (eligible[i]) begin
        win_id  = ID_W'(i);
        win_any = 1'b1;
      end
      if (in_service_q[i]) begin
        srv_id  = ID_W'(i);
        srv_any = 1'b1;
      end
    end
  end

`ifdef IRQ_NESTING_EN
  // Only a strictly higher-priority source may preempt the current service
  assign block = srv_any && (win_id <= srv_id);
`else
  assign block = srv_any;
`endif

  assign req_c    = win_any & ~block;
  assign ack_fire = irq_ack & req_c;
  assign ack_set  = ack_fire ? (N_SRC'(1) << win_id) : '0;
  assign eret_clr = (eret && srv_any) ? (N_SRC'(1) << srv_id) : '0;

  // Pending/in-service/mask update; a new edge wins over the ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
    end else begin
      pending_q    <= (pending_q & ~ack_set) | edge_det;
      in_service_q <= (in_service_q & ~eret_clr) | ack_set;
      if (mask_we) mask_q <= mask_din;
    end
  end

  // Outputs decode registered state only; id/vector park at 0/VEC_BASE when idle
  assign irq_req    = req_c;
  assign irq_id     = req_c ? win_id : '0;
  assign irq_vector = VEC_BASE + 32'(irq_id) * VEC_STRIDE;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller (N_SRC=3): vector table, corner sequences,
// and random stimulus against a cycle-level reference model.
module tb_irq_controller;

  localparam logic [31:0] VB = 32'h0000_0000;
  localparam logic [31:0] VS = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_din = '0;
  logic        eret = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vector;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [2:0]  mask;

  int errors = 0;
  int checks = 0;

  irq_controller #(.N_SRC(3), .SYNC_STAGES(2), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
    .eret(eret), .irq_ack(irq_ack), .irq_req(irq_req), .irq_id(irq_id),
    .irq_vector(irq_vector), .pending(pending), .in_service(in_service), .mask(mask)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2:0] m_pend, m_insvc, m_mask;
  logic [2:0] m_hist[$];  // m_hist[k] = irq_in sampled k+1 edges ago

  function automatic int top_bit(input logic [2:0] v);
    int r = -1;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic m_req();
    int w = top_bit(m_pend & ~m_mask);
    int t = top_bit(m_insvc);
    if (w < 0) return 1'b0;
`ifdef IRQ_NESTING_EN
    return (t < 0) || (w > t);
`else
    return t < 0;
`endif
  endfunction

  function automatic int m_id();
    return m_req() ? top_bit(m_pend & ~m_mask) : 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_insvc = '0; m_mask = '0;
    m_hist = '{3'b000, 3'b000, 3'b000};
  endtask

  // Applied at each active edge using the inputs present before it
  task automatic model_step();
    logic rq;
    int w, t;
    logic [2:0] rise;
    rq   = m_req();
    w    = top_bit(m_pend & ~m_mask);
    t    = top_bit(m_insvc);
    rise = m_hist[1] & ~m_hist[2];
    if (eret && t >= 0) m_insvc[t] = 1'b0;
    if (irq_ack && rq) begin
      m_pend[w]  = 1'b0;
      m_insvc[w] = 1'b1;
    end
    m_pend = m_pend | rise;
    if (mask_we) m_mask = mask_din;
    m_hist.push_front(irq_in);
    void'(m_hist.pop_back());
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [2:0] irq, input logic mwe, input logic [2:0] md,
                      input logic er, input logic ak);
    irq_in = irq; mask_we = mwe; mask_din = md; eret = er; irq_ack = ak;
    @(posedge clk);
    model_step();
    @(negedge clk);
    mask_we = 1'b0; eret = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    irq_in = '0; mask_we = 1'b0; mask_din = '0; eret = 1'b0; irq_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, " req"},     32'(irq_req),    32'(m_req()));
    chk({tag, " id"},      32'(irq_id),     32'(m_id()));
    chk({tag, " vec"},     irq_vector,      VB + 32'(m_id()) * VS);
    chk({tag, " pend"},    32'(pending),    32'(m_pend));
    chk({tag, " insvc"},   32'(in_service), 32'(m_insvc));
    chk({tag, " mask"},    32'(mask),       32'(m_mask));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] irq; logic mwe; logic [2:0] md; logic er; logic ak;
    logic req; logic [1:0] id; logic [31:0] vec;
    logic [2:0] pend; logic [2:0] insvc; logic [2:0] msk;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [2:0] irq, input logic mwe, input logic [2:0] md,
                     input logic er, input logic ak, input logic req, input logic [1:0] id,
                     input logic [31:0] vec, input logic [2:0] pend,
                     input logic [2:0] insvc, input logic [2:0] msk);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.md = md; v.er = er; v.ak = ak;
    v.req = req; v.id = id; v.vec = vec; v.pend = pend; v.insvc = insvc; v.msk = msk;
    tv.push_back(v);
  endtask

  initial begin
    //   irq     mwe md     er ak   req id vec     pend    insvc   mask
    add(3'b001, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b001, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b001, 0, 3'b000, 0, 0,   1, 0, 32'h00, 3'b001, 3'b000, 3'b000);
    add(3'b001, 0, 3'b000, 0, 1,   0, 0, 32'h00, 3'b000, 3'b001, 3'b000);
    add(3'b001, 0, 3'b000, 1, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b011, 0, 3'b000, 0, 0,   1, 1, 32'h20, 3'b011, 3'b000, 3'b000);
    add(3'b011, 0, 3'b000, 0, 1,   0, 0, 32'h00, 3'b001, 3'b010, 3'b000);
    add(3'b011, 0, 3'b000, 1, 0,   1, 0, 32'h00, 3'b001, 3'b000, 3'b000);
    add(3'b011, 0, 3'b000, 0, 1,   0, 0, 32'h00, 3'b000, 3'b001, 3'b000);
    add(3'b011, 0, 3'b000, 1, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);
    add(3'b000, 1, 3'b100, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b100);
    add(3'b100, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b100);
    add(3'b100, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b100);
    add(3'b100, 0, 3'b000, 0, 0,   0, 0, 32'h00, 3'b100, 3'b000, 3'b100);
    add(3'b100, 1, 3'b000, 0, 0,   1, 2, 32'h40, 3'b100, 3'b000, 3'b000);
    add(3'b100, 0, 3'b000, 0, 1,   0, 0, 32'h00, 3'b000, 3'b100, 3'b000);
    add(3'b000, 0, 3'b000, 1, 0,   0, 0, 32'h00, 3'b000, 3'b000, 3'b000);

    // Reset state
    do_reset();
    chk("rst req", 32'(irq_req), 0);
    chk("rst id", 32'(irq_id), 0);
    chk("rst vec", irq_vector, VB);
    chk("rst pend", 32'(pending), 0);

    // Table-driven vectors
    foreach (tv[i]) begin
      tick(tv[i].irq, tv[i].mwe, tv[i].md, tv[i].er, tv[i].ak);
      chk($sformatf("tv%0d req", i),   32'(irq_req),    32'(tv[i].req));
      chk($sformatf("tv%0d id", i),    32'(irq_id),     32'(tv[i].id));
      chk($sformatf("tv%0d vec", i),   irq_vector,      tv[i].vec);
      chk($sformatf("tv%0d pend", i),  32'(pending),    32'(tv[i].pend));
      chk($sformatf("tv%0d insvc", i), 32'(in_service), 32'(tv[i].insvc));
      chk($sformatf("tv%0d mask", i),  32'(mask),       32'(tv[i].msk));
    end

    // Async reset mid-service: in_service=100, pending=011, mask=010
    do_reset();
    repeat (3) tick(3'b100, 0, 3'b000, 0, 0);
    tick(3'b100, 1, 3'b010, 0, 1);
    repeat (3) tick(3'b111, 0, 3'b000, 0, 0);
    chk("mid insvc", 32'(in_service), 32'(3'b100));
    chk("mid pend", 32'(pending), 32'(3'b011));
    chk("mid mask", 32'(mask), 32'(3'b010));
    irq_in = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst req", 32'(irq_req), 0);
    chk("arst pend", 32'(pending), 0);
    chk("arst insvc", 32'(in_service), 0);
    chk("arst mask", 32'(mask), 0);
    chk("arst vec", irq_vector, VB);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Preemption / blocking by an in-service source
    do_reset();
    repeat (3) tick(3'b001, 0, 3'b000, 0, 0);
    chk("s5 req0", 32'(irq_req), 1);
    tick(3'b001, 0, 3'b000, 0, 1);
    chk("s5 insvc0", 32'(in_service), 32'(3'b001));
    repeat (3) tick(3'b101, 0, 3'b000, 0, 0);
    chk("s5 pend2", 32'(pending), 32'(3'b100));
`ifdef IRQ_NESTING_EN
    chk("s5 preempt req", 32'(irq_req), 1);
    chk("s5 preempt id", 32'(irq_id), 2);
    tick(3'b101, 0, 3'b000, 0, 1);
    chk("s5 nest insvc", 32'(in_service), 32'(3'b101));
    tick(3'b101, 0, 3'b000, 1, 0);
    chk("s5 pop insvc", 32'(in_service), 32'(3'b001));
    chk("s5 pop req", 32'(irq_req), 0);
`else
    chk("s5 blocked req", 32'(irq_req), 0);
    tick(3'b101, 0, 3'b000, 0, 1);
    chk("s5 ign insvc", 32'(in_service), 32'(3'b001));
    chk("s5 ign pend", 32'(pending), 32'(3'b100));
    tick(3'b101, 0, 3'b000, 1, 0);
    chk("s5 eret insvc", 32'(in_service), 0);
    chk("s5 eret req", 32'(irq_req), 1);
    chk("s5 eret id", 32'(irq_id), 2);
    chk("s5 eret vec", irq_vector, 32'h40);
`endif

    // Ack coinciding with a new edge on the same source; eret+ack together
    do_reset();
    tick(3'b001, 0, 3'b000, 0, 0);
    tick(3'b000, 0, 3'b000, 0, 0);
    tick(3'b001, 0, 3'b000, 0, 0);
    tick(3'b001, 0, 3'b000, 0, 0);
    chk("s6 req", 32'(irq_req), 1);
    tick(3'b001, 0, 3'b000, 0, 1);
    chk("s6 pend kept", 32'(pending), 32'(3'b001));
    chk("s6 insvc set", 32'(in_service), 32'(3'b001));
`ifdef IRQ_NESTING_EN
    repeat (3) tick(3'b101, 0, 3'b000, 0, 0);
    chk("s6 req2", 32'(irq_id), 2);
    tick(3'b101, 0, 3'b000, 1, 1);
    chk("s6 swap insvc", 32'(in_service), 32'(3'b100));
    chk("s6 swap pend", 32'(pending), 32'(3'b001));
`else
    tick(3'b001, 0, 3'b000, 1, 1);
    chk("s6 eret insvc", 32'(in_service), 0);
    chk("s6 eret pend", 32'(pending), 32'(3'b001));
    chk("s6 eret req", 32'(irq_req), 1);
`endif

    // Random stimulus against the reference model
    do_reset();
    begin
      logic [2:0] lines = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, 3) == 0) lines[b] = ~lines[b];
        tick(lines,
             ($urandom_range(0, 7) == 0),
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 1) == 1));
        check_model($sformatf("rnd%0d", c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
